// File: rtl/alu_op_sequencer_pkg.sv
// Shared encodings for the ALU op sequencer: request opcodes, ALU control
// codes, FSM states and the multiply step count.
package alu_op_sequencer_pkg;

    // Request opcodes on req_op
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // ALU operation select on alu_operation
    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_SUM = 2'b10;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_MUL  = 2'b10;
    localparam logic [1:0] ST_RESP = 2'b11;

    // Shift-add multiply runs one step per operand bit
    localparam int unsigned MUL_STEPS = 32;
    localparam int unsigned CNT_W     = $clog2(MUL_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

    // MUL is only legal when the multiplier is built in
    function automatic logic op_is_legal(input logic [2:0] op, input logic mul_en);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_is_legal = 1'b1;
            OP_MUL:                                op_is_legal = mul_en;
            default:                               op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer_mul_shift_regs.sv
// Shift-add multiplier state: partial product P, shifted multiplicand M,
// multiplier Q (consumed LSB first) and the step counter.
module alu_op_sequencer_mul_shift_regs
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_sum,
    output logic [WIDTH-1:0] o_p,
    output logic [WIDTH-1:0] o_m,
    output logic             o_q0,
    output logic             o_last
);

    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;

    // Load operands on acceptance, then add M into P for each set bit of Q
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p   <= '0;
            r_m   <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_p   <= '0;
            r_m   <= i_a;
            r_q   <= i_b;
            r_cnt <= '0;
        end else if (i_step) begin
            if (r_q[0]) begin
                r_p <= i_sum;
            end
            r_m   <= r_m << 1;
            r_q   <= r_q >> 1;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_p    = r_p;
    assign o_m    = r_m;
    assign o_q0   = r_q[0];
    assign o_last = (r_cnt == CNT_LAST);

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side driver for the external 32-bit ALU: accepts op requests,
// drives ALU control for one cycle (or 32 for MUL) and returns the result.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic             alu_binvert,
    output logic             alu_cin,
    output logic [1:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_err;

    logic             w_accept;
    logic             w_legal;
    logic             w_mul_load;
    logic             w_mul_step;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_m;
    logic             w_q0;
    logic             w_mul_last;
    logic             w_ovf;
    logic [WIDTH-1:0] w_exec_result;
    logic             w_exec_carry;

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_legal    = op_is_legal(req_op, MUL_EN);
    assign w_mul_load = w_accept && w_legal && (req_op == OP_MUL);
    assign w_mul_step = (r_state == ST_MUL);

    alu_op_sequencer_mul_shift_regs #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_mul_load),
        .i_step  (w_mul_step),
        .i_a     (req_a),
        .i_b     (req_b),
        .i_sum   (alu_result),
        .o_p     (w_p),
        .o_m     (w_m),
        .o_q0    (w_q0),
        .o_last  (w_mul_last)
    );

    // SLT uses the signed less-than of the subtraction, corrected for overflow
    always_comb begin
        w_ovf         = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (alu_result[WIDTH-1] != r_a[WIDTH-1]);
        w_exec_result = alu_result;
        w_exec_carry  = 1'b0;
        if (r_op == OP_SLT) begin
            w_exec_result = '0;
            w_exec_result[0] = alu_result[WIDTH-1] ^ w_ovf;
        end
        if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
            w_exec_carry = alu_cout;
        end
    end

    // Drive the ALU only in EXEC and MUL steps; idle/response hold it at zero
    always_comb begin
        alu_in1       = '0;
        alu_in2       = '0;
        alu_binvert   = 1'b0;
        alu_cin       = 1'b0;
        alu_operation = ALU_AND;
        if (r_state == ST_EXEC) begin
            alu_in1 = r_a;
            alu_in2 = r_b;
            case (r_op)
                OP_OR:  alu_operation = ALU_OR;
                OP_ADD: alu_operation = ALU_SUM;
                OP_SUB, OP_SLT: begin
                    alu_operation = ALU_SUM;
                    alu_binvert   = 1'b1;
                    alu_cin       = 1'b1;
                end
                default: alu_operation = ALU_AND;
            endcase
        end else if (r_state == ST_MUL) begin
            alu_in1       = w_p;
            alu_in2       = w_m;
            alu_operation = ALU_SUM;
        end
    end

    // Request/execute/response sequencing; response fields held until taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= req_op;
                        r_a  <= req_a;
                        r_b  <= req_b;
                        if (!w_legal) begin
                            r_result <= '0;
                            r_carry  <= 1'b0;
                            r_err    <= 1'b1;
                            r_state  <= ST_RESP;
                        end else if (req_op == OP_MUL) begin
                            r_state <= ST_MUL;
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    r_result <= w_exec_result;
                    r_carry  <= w_exec_carry;
                    r_err    <= 1'b0;
                    r_state  <= ST_RESP;
                end
                ST_MUL: begin
                    // P updates on this same edge, so take the post-step value
                    if (w_mul_last) begin
                        r_result <= w_q0 ? alu_result : w_p;
                        r_carry  <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= ST_RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE) && reset_n;
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_result = r_result;
    assign rsp_carry  = r_carry;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU and a
// behavioural reference model of each op's result, carry, error and latency.
module tb_alu_op_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_err;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic        alu_binvert;
    logic        alu_cin;
    logic [1:0]  alu_operation;
    logic [31:0] alu_result;
    logic        alu_cout;

    int n_checks = 0;
    int n_errors = 0;

    alu_op_sequencer #(
        .WIDTH  (32),
        .MUL_EN (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_carry     (rsp_carry),
        .rsp_err       (rsp_err),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_binvert   (alu_binvert),
        .alu_cin       (alu_cin),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_cout      (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 32-bit ALU: AND / OR / add with optional B inversion and carry-in
    always_comb begin
        logic [31:0] bb;
        logic [32:0] s;
        bb = alu_binvert ? ~alu_in2 : alu_in2;
        s  = {1'b0, alu_in1} + {1'b0, bb} + {32'b0, alu_cin};
        alu_cout = s[32];
        case (alu_operation)
            2'b00:   alu_result = alu_in1 & bb;
            2'b01:   alu_result = alu_in1 | bb;
            2'b10:   alu_result = s[31:0];
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: what each op should return, straight from its definition
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic c, output logic e,
                                   output int lat);
        logic [63:0] prod;
        r = '0; c = 1'b0; e = 1'b0; lat = 2;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: {c, r} = {1'b0, a} + {1'b0, b};
            3'b110: begin r = a - b; c = (a >= b); end
            3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011: begin prod = {32'b0, a} * {32'b0, b}; r = prod[31:0]; lat = 33; end
            default: begin e = 1'b1; lat = 1; end
        endcase
    endfunction

    // One request/response transaction, with `hold` cycles of response backpressure
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        ec;
        logic        ee;
        int          elat;
        int          cycles;
        int          busy_seen;
        ref_op(op, a, b, er, ec, ee, elat);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        check("req_ready_idle", {63'b0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = $urandom_range(0, 7); req_a = $urandom; req_b = $urandom;
        if (elat == 2) begin
            check("alu_ctrl", {58'b0, alu_operation, alu_binvert, alu_cin, 2'b0},
                  {58'b0, (op == 3'b000) ? 2'b00 : (op == 3'b001) ? 2'b01 : 2'b10,
                   (op[2] == 1'b1), (op[2] == 1'b1), 2'b0});
            check("alu_operands", {alu_in1, alu_in2}, {a, b});
        end
        cycles = 1;
        busy_seen = 0;
        while (!rsp_valid && cycles < 100) begin
            if (req_ready) busy_seen++;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("latency", 64'(cycles), 64'(elat));
        check("busy_not_ready", 64'(busy_seen), 64'd0);
        check("rsp_result", {32'b0, rsp_result}, {32'b0, er});
        check("rsp_carry_err", {62'b0, rsp_carry, rsp_err}, {62'b0, ec, ee});
        check("alu_idle_resp", {alu_in1, alu_in2}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_state", {30'b0, rsp_valid, req_ready, rsp_result}, {30'b0, 1'b1, 1'b0, er});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("after_handshake", {62'b0, rsp_valid, req_ready}, {62'b0, 1'b0, 1'b1});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {59'b0, req_ready, rsp_valid, rsp_carry, rsp_err, alu_binvert},
              64'd0);
        check({tag, "_res"}, {32'b0, rsp_result}, 64'd0);
        check({tag, "_alu"}, {alu_in1, alu_in2}, 64'd0);
        check({tag, "_aluop"}, {62'b0, alu_operation} | {63'b0, alu_cin}, 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       pick_operand = 32'hFFFF_FFFF;
            1:       pick_operand = 32'h8000_0000;
            2:       pick_operand = 32'h7FFF_FFFF;
            3:       pick_operand = 32'(($urandom_range(0, 15)));
            default: pick_operand = $urandom;
        endcase
    endfunction

    initial begin
        int stray;
        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        do_op(3'b010, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(3'b110, 32'd5, 32'd7, 0);
        do_op(3'b110, 32'd7, 32'd5, 0);
        do_op(3'b111, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        do_op(3'b111, 32'd3, 32'd3, 0);
        do_op(3'b011, 32'h0001_0001, 32'h0001_0001, 0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5);
        do_op(3'b001, 32'h1234_0000, 32'h0000_5678, 0);
        do_op(3'b101, 32'h1, 32'h2, 0);
        do_op(3'b100, 32'hDEAD_BEEF, 32'h1, 1);

        // Reset in the middle of a multiply: everything clears, no response follows
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b011; req_a = 32'h0000_1234; req_b = 32'hFFFF_0001;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) stray++;
        end
        check("no_rsp_after_abort", 64'(stray), 64'd0);
        do_op(3'b010, 32'd2, 32'd3, 0);

        // Randomized mix of all eight opcodes
        for (int n = 0; n < 40; n++) begin
            do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
